// File: rtl/serial_right_shifter_pkg.sv
// Shared definitions for the serial right-shift unit: FSM encoding, shift-mode
// constants and the fill-bit rule.
package serial_right_shifter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic ShiftLogical = 1'b0;
  localparam logic ShiftArith   = 1'b1;

  // Bit entering at the MSB on each single-position step.
  function automatic logic fill_bit(input logic mode, input logic msb);
    return (mode == ShiftArith) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/serial_right_shifter_if.sv
// Operand/result handshake bundle for the serial right shifter.
interface serial_right_shifter_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 4
);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [SW-1:0] shift;
  logic          arith;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out;
  logic          cout;
  logic          zero;

  modport master (
    output in_valid,
    output in_a,
    output shift,
    output arith,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out,
    input  cout,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  shift,
    input  arith,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out,
    output cout,
    output zero
  );

endinterface

// File: rtl/serial_right_shifter_shift_step_1bit.sv
// Combinational single-position right shift with an explicit fill bit.
module serial_right_shifter_shift_step_1bit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] din,
  input  logic         fill,
  output logic [N-1:0] dout,
  output logic         cout
);

  assign dout = {fill, din[N-1:1]};
  assign cout = din[0];

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter: one bit position per clock, logical or arithmetic,
// valid/ready on both sides, registered result held until taken.
module serial_right_shifter
  import serial_right_shifter_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_right_shifter_if.slave  bus
);

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [SW-1:0] count_q, count_d;
  logic          mode_q, mode_d;

  logic [N-1:0]  res_q, res_d;
  logic          res_cout_q, res_cout_d;
  logic          res_zero_q, res_zero_d;
  logic          res_valid_q, res_valid_d;

  logic [N-1:0]  step_data;
  logic          step_cout;
  logic          step_fill;

  assign step_fill = fill_bit(mode_q, data_q[N-1]);

  serial_right_shifter_shift_step_1bit #(
    .N(N)
  ) u_step (
    .din  (data_q),
    .fill (step_fill),
    .dout (step_data),
    .cout (step_cout)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    count_d     = count_q;
    mode_d      = mode_q;
    res_d       = res_q;
    res_cout_d  = res_cout_q;
    res_zero_d  = res_zero_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.in_a;
          count_d = bus.shift;
          mode_d  = bus.arith ? ShiftArith : ShiftLogical;
          if (bus.shift == '0) begin
            // Zero-length shift: result is the operand itself, no bit shifted out.
            state_d     = StDone;
            res_d       = bus.in_a;
            res_cout_d  = 1'b0;
            res_zero_d  = (bus.in_a == '0);
            res_valid_d = 1'b1;
          end else begin
            state_d = StShift;
          end
        end
      end

      StShift: begin
        data_d  = step_data;
        count_d = count_q - SW'(1);
        if (count_q == SW'(1)) begin
          state_d     = StDone;
          res_d       = step_data;
          res_cout_d  = step_cout;
          res_zero_d  = (step_data == '0);
          res_valid_d = 1'b1;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          // Result taken: outputs return to their idle values.
          state_d     = StIdle;
          res_d       = '0;
          res_cout_d  = 1'b0;
          res_zero_d  = 1'b1;
          res_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      count_q     <= '0;
      mode_q      <= ShiftLogical;
      res_q       <= '0;
      res_cout_q  <= 1'b0;
      res_zero_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      res_q       <= res_d;
      res_cout_q  <= res_cout_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = res_valid_q;
  assign bus.out       = res_q;
  assign bus.cout      = res_cout_q;
  assign bus.zero      = res_zero_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_ready && bus.out_valid));

  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out) && $stable(bus.cout) && $stable(bus.zero)));

endmodule

// File: tb/tb_serial_right_shifter.sv
// Bench for serial_right_shifter: directed table, backpressure, mid-operation
// reset and randomized back-to-back traffic against a behavioural model.
module tb_serial_right_shifter;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_right_shifter_if #(.N(N), .SW(SW)) bus ();

  serial_right_shifter #(
    .N  (N),
    .SW (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] a;
    int           sh;
    logic         ar;
    logic [N-1:0] eout;
    logic         ecout;
    logic         ezero;
    int           elat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Sign- or zero-extend, shift with plain arithmetic; cout is the bit just below
  // the surviving field of the extended operand.
  task automatic model(input logic [N-1:0] a, input int sh, input logic ar,
                       output logic [N-1:0] o, output logic c);
    logic signed [31:0] ext;
    ext = {{(32 - N){ar & a[N-1]}}, a};
    o   = N'(ext >>> sh);
    c   = (sh == 0) ? 1'b0 : ext[sh-1];
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [N-1:0] a, input int sh, input logic ar,
                        output logic [N-1:0] o, output logic c, output logic z,
                        output int lat, output int busy_hi, output longint acc_t);
    int w;
    bus.in_a     = a;
    bus.shift    = sh[SW-1:0];
    bus.arith    = ar;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", w);
    end
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat     = 1;
    busy_hi = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) busy_hi++;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready) busy_hi++;
    o = bus.out;
    c = bus.cout;
    z = bus.zero;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] o, eo, keep_o;
    logic         c, z, ec, keep_c, keep_z;
    int           lat, busy, sh, prev_sh;
    longint       acc_t, prev_t;
    logic [N-1:0] a;
    logic         ar;

    tbl[0] = '{8'hF0, 1,  1'b0, 8'h78, 1'b0, 1'b0, 2};
    tbl[1] = '{8'hF0, 3,  1'b0, 8'h1E, 1'b0, 1'b0, 4};
    tbl[2] = '{8'hF0, 6,  1'b0, 8'h03, 1'b1, 1'b0, 7};
    tbl[3] = '{8'h96, 2,  1'b1, 8'hE5, 1'b1, 1'b0, 3};
    tbl[4] = '{8'h96, 8,  1'b1, 8'hFF, 1'b1, 1'b0, 9};
    tbl[5] = '{8'h96, 8,  1'b0, 8'h00, 1'b1, 1'b1, 9};
    tbl[6] = '{8'hA5, 0,  1'b0, 8'hA5, 1'b0, 1'b0, 1};
    tbl[7] = '{8'hFF, 15, 1'b0, 8'h00, 1'b0, 1'b1, 16};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.shift     = '0;
    bus.arith     = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",       32'(bus.out),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_zero",      32'(bus.zero),      32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].sh, tbl[i].ar, o, c, z, lat, busy, acc_t);
      check($sformatf("tbl%0d_out", i),  32'(o),    32'(tbl[i].eout));
      check($sformatf("tbl%0d_cout", i), 32'(c),    32'(tbl[i].ecout));
      check($sformatf("tbl%0d_zero", i), 32'(z),    32'(tbl[i].ezero));
      check($sformatf("tbl%0d_lat", i),  32'(lat),  32'(tbl[i].elat));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
    end
    @(negedge clk);

    // Backpressure: result must hold while stray in_valid pulses are ignored.
    bus.out_ready = 1'b0;
    run_op(8'h3C, 2, 1'b0, o, c, z, lat, busy, acc_t);
    check("bp_out",  32'(o), 32'h0F);
    check("bp_cout", 32'(c), 32'd0);
    keep_o = o;
    keep_c = c;
    keep_z = z;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0];
      bus.in_a     = 8'hFF;
      bus.shift    = '0;
      @(negedge clk);
      check($sformatf("bp_hold%0d", k),
            {20'd0, bus.out_valid, bus.in_ready, bus.zero, bus.cout, bus.out},
            {20'd0, 1'b1, 1'b0, keep_z, keep_c, keep_o});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    check("bp_no_ghost", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset during a shift=7 operation.
    bus.in_a     = 8'hC3;
    bus.shift    = 4'd7;
    bus.arith    = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("midrst_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out",       32'(bus.out),       32'd0);
    check("midrst_cout",      32'(bus.cout),      32'd0);
    check("midrst_zero",      32'(bus.zero),      32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'h81, 1, 1'b0, o, c, z, lat, busy, acc_t);
    check("postrst_out",  32'(o),   32'h40);
    check("postrst_cout", 32'(c),   32'd1);
    check("postrst_lat",  32'(lat), 32'd2);

    // Randomized back-to-back traffic, out_ready held high.
    prev_t  = 0;
    prev_sh = 0;
    for (int i = 0; i < 500; i++) begin
      a  = N'($urandom);
      sh = int'($urandom_range(0, (1 << SW) - 1));
      ar = 1'($urandom);
      model(a, sh, ar, eo, ec);
      run_op(a, sh, ar, o, c, z, lat, busy, acc_t);
      check($sformatf("rnd%0d_out a=%0h sh=%0d ar=%0d", i, a, sh, ar), 32'(o), 32'(eo));
      check($sformatf("rnd%0d_cout", i), 32'(c), 32'(ec));
      check($sformatf("rnd%0d_zero", i), 32'(z), 32'(eo == '0));
      if (i > 0) begin
        check($sformatf("rnd%0d_gap", i), 32'((acc_t - prev_t) / 10), 32'(prev_sh + 2));
      end
      prev_t  = acc_t;
      prev_sh = sh;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
